fixed_neg_exp_interp: RTL

//  Pipelined fixed-point e^(-x) unit, successor of the fixed 8-entry fractional LUT.

---
 rtl/fixed_neg_exp_interp_pkg.sv | 32 +++
 rtl/fixed_neg_exp_interp_if.sv | 25 ++
 rtl/fixed_neg_exp_interp_lut.sv | 34 +++
 rtl/fixed_neg_exp_interp.sv | 114 +++++++++++
 4 files changed

// File: rtl/fixed_neg_exp_interp_pkg.sv
// Shared constants and elaboration-time helpers for the e^(-x) datapath.
//   LOG2E_Q16        log2(e) in Q1.16; S1 multiplies x by this value
//   prod_width/frac  width and fractional bits of the S1 product
//   resid_width      width of the interpolation fraction below the LUT index
//   neg_exp2_entry   one ROM entry, round(2^(-i/2^addr_w) * 2^frac_w)
package fixed_neg_exp_interp_pkg;

    localparam int              LOG2E_WIDTH = 17;
    localparam int              LOG2E_FRAC  = 16;
    localparam logic [16:0]     LOG2E_Q16   = 17'h17154;
    localparam int              RESID_MAX   = 16;

    function automatic int prod_width(input int din_w);
        return din_w + LOG2E_WIDTH;
    endfunction

    function automatic int prod_frac(input int din_frac);
        return din_frac + LOG2E_FRAC;
    endfunction

    function automatic int resid_width(input int fp, input int addr_w);
        return ((fp - addr_w) < RESID_MAX) ? (fp - addr_w) : RESID_MAX;
    endfunction

    // Only ever evaluated at elaboration, so real math is safe here.
    function automatic int neg_exp2_entry(input int i, input int addr_w, input int frac_w);
        real v;
        v = (2.0 ** (-real'(i) / real'(2 ** addr_w))) * real'(2 ** frac_w);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/fixed_neg_exp_interp_if.sv
// Valid/ready stream bundle for the e^(-x) unit: one input stream (x) and
// one output stream (e^(-x)).
//   master : the producer/consumer around the unit (drives x, valid, downstream ready)
//   slave  : the unit itself
interface fixed_neg_exp_interp_if #(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 17
);
    logic [DIN_W-1:0]  data_in_0;
    logic              data_in_0_valid;
    logic              data_in_0_ready;
    logic [DOUT_W-1:0] data_out_0;
    logic              data_out_0_valid;
    logic              data_out_0_ready;

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid
    );

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid
    );
endinterface

// File: rtl/fixed_neg_exp_interp_lut.sv
// Elaborated ROM of 2^(-i/2^LUT_ADDR_WIDTH), i = 0 .. 2^LUT_ADDR_WIDTH
// (one extra endpoint entry equal to 0.5, so the top segment can interpolate
// without wrapping).
//   idx_i       segment index
//   entry_lo_o  ROM[idx_i]
//   entry_hi_o  ROM[idx_i + 1]
module neg_exp2_lut
    import fixed_neg_exp_interp_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH      = 5,
    parameter int DATA_OUT_WIDTH      = 17,
    parameter int DATA_OUT_FRAC_WIDTH = 16
) (
    input  logic [LUT_ADDR_WIDTH-1:0] idx_i,
    output logic [DATA_OUT_WIDTH-1:0] entry_lo_o,
    output logic [DATA_OUT_WIDTH-1:0] entry_hi_o
);
    localparam int DEPTH = 2 ** LUT_ADDR_WIDTH;

    logic [DATA_OUT_WIDTH-1:0] rom [0:DEPTH];
    logic [LUT_ADDR_WIDTH:0]   addr_lo;
    logic [LUT_ADDR_WIDTH:0]   addr_hi;

    for (genvar i = 0; i <= DEPTH; i++) begin : g_rom
        localparam int ENTRY = neg_exp2_entry(i, LUT_ADDR_WIDTH, DATA_OUT_FRAC_WIDTH);
        assign rom[i] = DATA_OUT_WIDTH'(ENTRY);
    end

    assign addr_lo    = {1'b0, idx_i};
    assign addr_hi    = addr_lo + 1'b1;
    assign entry_lo_o = rom[addr_lo];
    assign entry_hi_o = rom[addr_hi];

endmodule

// File: rtl/fixed_neg_exp_interp.sv
// Pipelined e^(-x) = 2^(-x*log2e) for the softmax datapath.
//   S1: p = x * log2(e)
//   S2: split p into integer k and fraction f, look up / interpolate 2^(-f),
//       flag saturation when k is too large for any bit to survive
//   S3: y = m >> k
// All three stages share one advance enable, so a downstream stall freezes
// the whole pipe and the output holds steady.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; drops everything in flight
//   bus  slave side of the stream bundle (x in, e^(-x) out, valid/ready each way)
module fixed_neg_exp_interp
    import fixed_neg_exp_interp_pkg::*;
#(
    parameter int DATA_IN_WIDTH       = 16,
    parameter int DATA_IN_FRAC_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH      = 17,
    parameter int DATA_OUT_FRAC_WIDTH = 16,
    parameter int LUT_ADDR_WIDTH      = 5,
    parameter bit INTERP_EN           = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    fixed_neg_exp_interp_if.slave bus
);
    localparam int PW  = prod_width(DATA_IN_WIDTH);
    localparam int FP  = prod_frac(DATA_IN_FRAC_WIDTH);
    localparam int KW  = PW - FP;
    localparam int RW  = resid_width(FP, LUT_ADDR_WIDTH);
    localparam int DOW = DATA_OUT_WIDTH;
    localparam int SHW = $clog2(DATA_OUT_WIDTH);

    logic           en;
    logic           v1_q, v2_q, v3_q;
    logic [PW-1:0]  p_d, p_q;
    logic [KW-1:0]  k_s2;
    logic [LUT_ADDR_WIDTH-1:0] idx_s2;
    logic [RW-1:0]  r_s2;
    logic [DOW-1:0] lut_lo, lut_hi;
    logic [DOW-1:0] m_d, m_q;
    logic           sat_d, sat_q;
    logic [SHW-1:0] sh_d, sh_q;
    logic [DOW-1:0] y_d, y_q;
    logic           unused_p;

    assign en                   = !v3_q || bus.data_out_0_ready;
    assign bus.data_in_0_ready  = en;
    assign bus.data_out_0       = y_q;
    assign bus.data_out_0_valid = v3_q;

    // S1
    assign p_d = PW'(bus.data_in_0) * PW'(LOG2E_Q16);

    // S2: index from the top fraction bits, interpolation weight from the
    // bits right below it; anything further down is too small to matter.
    assign k_s2     = p_q[PW-1:FP];
    assign idx_s2   = p_q[FP-1 -: LUT_ADDR_WIDTH];
    assign r_s2     = p_q[FP-LUT_ADDR_WIDTH-1 -: RW];
    assign unused_p = ^p_q;

    neg_exp2_lut #(
        .LUT_ADDR_WIDTH      (LUT_ADDR_WIDTH),
        .DATA_OUT_WIDTH      (DATA_OUT_WIDTH),
        .DATA_OUT_FRAC_WIDTH (DATA_OUT_FRAC_WIDTH)
    ) u_lut (
        .idx_i      (idx_s2),
        .entry_lo_o (lut_lo),
        .entry_hi_o (lut_hi)
    );

    if (INTERP_EN) begin : g_interp
        logic [DOW-1:0]    diff;
        logic [DOW+RW-1:0] prod;
        // The table is decreasing, so diff never underflows and the
        // correction never exceeds diff: m stays between the two entries.
        assign diff = lut_lo - lut_hi;
        assign prod = (DOW+RW)'(diff) * (DOW+RW)'(r_s2);
        assign m_d  = lut_lo - prod[DOW+RW-1:RW];
    end else begin : g_trunc
        logic unused_interp;
        assign unused_interp = ^{lut_hi, r_s2};
        assign m_d           = lut_lo;
    end

    // Any k >= DATA_OUT_WIDTH shifts every bit of m (<= 1.0) out.
    assign sat_d = (k_s2 >= KW'(DATA_OUT_WIDTH));
    assign sh_d  = sat_d ? '0 : k_s2[SHW-1:0];

    // S3
    assign y_d = sat_q ? '0 : (m_q >> sh_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            p_q   <= '0;
            m_q   <= '0;
            sat_q <= 1'b0;
            sh_q  <= '0;
            y_q   <= '0;
        end else if (en) begin
            v1_q  <= bus.data_in_0_valid;
            p_q   <= p_d;
            v2_q  <= v1_q;
            m_q   <= m_d;
            sat_q <= sat_d;
            sh_q  <= sh_d;
            v3_q  <= v2_q;
            y_q   <= y_d;
        end
    end

endmodule
